// File: rtl/pwm_gen_multi_if.sv
// Control/status bundle between the register file and the PWM generator.
// duty_in is packed per channel: channel i lives in duty_in[i], which is
// bit-identical to a flat [i*CNT_WIDTH +: CNT_WIDTH] slice.
interface pwm_gen_multi_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16
);
    logic                                enable;
    logic                                center_mode;
    logic [CNT_WIDTH-1:0]                period_in;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]    duty_in;
    logic [NUM_CH-1:0]                   invert_in;
    logic                                update;
    logic [NUM_CH-1:0]                   pwm_out;
    logic                                period_tick;
    logic                                update_ack;

    modport master (
        output enable, center_mode, period_in, duty_in, invert_in, update,
        input  pwm_out, period_tick, update_ack
    );

    modport slave (
        input  enable, center_mode, period_in, duty_in, invert_in, update,
        output pwm_out, period_tick, update_ack
    );
endinterface

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: one shared up / up-down period counter,
// per-channel double-buffered duty and polarity, loads only at a period
// boundary (or continuously while disabled) so no runt pulses are emitted.

// Per-channel lane: active duty/polarity registers and the registered output.
module pwm_gen_multi_lane #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 run,
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic [CNT_WIDTH-1:0] duty_in,
    input  logic                 inv_in,
    output logic                 pwm_q
);
    logic [CNT_WIDTH-1:0] duty_act_q, duty_act_d;
    logic                 inv_act_q, inv_act_d;
    logic                 pwm_d;

    // Shadow load and output compare; idle lanes sit at their inactive level.
    always_comb begin
        duty_act_d = load ? duty_in : duty_act_q;
        inv_act_d  = load ? inv_in  : inv_act_q;
        pwm_d      = run ? ((cnt < duty_act_q) ^ inv_act_q) : inv_act_q;
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_act_q <= '0;
            inv_act_q  <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            duty_act_q <= duty_act_d;
            inv_act_q  <= inv_act_d;
            pwm_q      <= pwm_d;
        end
    end
endmodule

module pwm_gen_multi #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    pwm_gen_multi_if.slave bus
);
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // en_q delays enable by one cycle: the counter and outputs follow en_q,
    // which gives the one-cycle start-up / shut-down skew at enable edges.
    logic              en_q, en_d;
    cnt_t              cnt_q, cnt_d;
    logic              down_q, down_d;
    cnt_t              n_act_q, n_act_d;
    logic              mode_act_q, mode_act_d;
    logic              pend_q, pend_d;
    logic              ld_q, ld_d;
    logic              tick_q, tick_d;
    logic              ack_q, ack_d;
    logic              boundary, service, load;
    logic [NUM_CH-1:0] pwm_bits;

    // Period boundary detect and shadow-load decision.
    always_comb begin
        boundary = mode_act_q ? (down_q && (cnt_q == '0)) : (cnt_q == n_act_q);
        service  = bus.enable && en_q && boundary && (pend_q || bus.update);
        load     = !bus.enable || service;
    end

    // Next counter value and direction.
    always_comb begin
        en_d   = bus.enable;
        cnt_d  = cnt_q;
        down_d = down_q;
        if (!bus.enable || !en_q || boundary) begin
            cnt_d  = '0;
            down_d = 1'b0;
        end else if (!mode_act_q) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (!down_q) begin
            // Top value is held one extra cycle while turning around.
            if (cnt_q == n_act_q) down_d = 1'b1;
            else                  cnt_d  = cnt_q + cnt_t'(1);
        end else begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    // Shared shadows, pending flag and status pulses.
    always_comb begin
        n_act_d    = load ? bus.period_in   : n_act_q;
        mode_act_d = load ? bus.center_mode : mode_act_q;
        pend_d     = bus.enable && !service && (pend_q || bus.update);
        ld_d       = service;
        // ld_q is one cycle behind the load so the ack lines up with the tick.
        tick_d     = en_q && (cnt_q == '0) && !down_q;
        ack_d      = en_q && ld_q;
    end

    // Shared state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= 1'b0;
            cnt_q      <= '0;
            down_q     <= 1'b0;
            n_act_q    <= '0;
            mode_act_q <= 1'b0;
            pend_q     <= 1'b0;
            ld_q       <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            down_q     <= down_d;
            n_act_q    <= n_act_d;
            mode_act_q <= mode_act_d;
            pend_q     <= pend_d;
            ld_q       <= ld_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        pwm_gen_multi_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load),
            .run     (en_q),
            .cnt     (cnt_q),
            .duty_in (bus.duty_in[i]),
            .inv_in  (bus.invert_in[i]),
            .pwm_q   (pwm_bits[i])
        );
    end

    assign bus.pwm_out     = pwm_bits;
    assign bus.period_tick = tick_q;
    assign bus.update_ack  = ack_q;
endmodule

// File: tb/tb_pwm_gen_multi.sv
// Directed bench for pwm_gen_multi: stimulus pushes the hand-derived output
// expected for each cycle, a negedge monitor pops and compares.
module tb_pwm_gen_multi;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    pwm_gen_multi_if #(.NUM_CH(4), .CNT_WIDTH(16)) bus ();

    pwm_gen_multi #(.NUM_CH(4), .CNT_WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] pwm;
        logic       tick;
        logic       ack;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.pwm_out !== e.pwm || bus.period_tick !== e.tick || bus.update_ack !== e.ack) begin
                errors++;
                $display("FAIL %s @%0t: got pwm=%b tick=%b ack=%b, want pwm=%b tick=%b ack=%b",
                         e.name, $time, bus.pwm_out, bus.period_tick, bus.update_ack,
                         e.pwm, e.tick, e.ack);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Push the expectation for the current cycle, then advance one cycle.
    task automatic step(input logic [3:0] p, input logic t, input logic a, input string nm);
        exp_t e;
        e.pwm = p; e.tick = t; e.ack = a; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input logic [15:0] d3, input logic [15:0] d2,
                            input logic [15:0] d1, input logic [15:0] d0);
        bus.duty_in = {d3, d2, d1, d0};
    endtask

    initial begin
        logic [3:0] ep;
        int c;
        reset_n         = 1'b1;
        bus.enable      = 1'b0;
        bus.center_mode = 1'b0;
        bus.period_in   = 16'd9;
        bus.invert_in   = 4'b0000;
        bus.update      = 1'b0;
        set_duty(16'd15, 16'd10, 16'd3, 16'd0);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;

        step(4'b0000, 1'b0, 1'b0, "reset");
        step(4'b0000, 1'b0, 1'b0, "reset");
        reset_n = 1'b1;
        step(4'b0000, 1'b0, 1'b0, "disabled");
        step(4'b0000, 1'b0, 1'b0, "disabled");

        // Edge mode N=9, duties {15,10,3,0}.
        bus.enable = 1'b1;
        step(4'b0000, 1'b0, 1'b0, "enable_c0");
        step(4'b0000, 1'b0, 1'b0, "enable_c1");
        for (int k = 0; k < 30; k++) begin
            ep = 4'b1100; ep[1] = (k % 10) < 3;
            step(ep, (k % 10) == 0, 1'b0, "edge_run");
        end

        // Duty change without update is ignored; update mid-period applies next period.
        set_duty(16'd15, 16'd10, 16'd7, 16'd0);
        for (int k = 30; k < 50; k++) begin
            bus.update = (k == 44);
            ep = 4'b1100; ep[1] = (k % 10) < 3;
            step(ep, (k % 10) == 0, 1'b0, "duty_hold");
        end
        bus.update = 1'b0;
        for (int k = 50; k < 70; k++) begin
            ep = 4'b1100; ep[1] = (k % 10) < 7;
            step(ep, (k % 10) == 0, k == 50, "duty_upd");
        end

        // Period 9->4 and edge->center on one update.
        bus.period_in   = 16'd4;
        bus.center_mode = 1'b1;
        set_duty(16'd4, 16'd5, 16'd3, 16'd0);
        for (int k = 70; k < 80; k++) begin
            bus.update = (k == 72);
            ep = 4'b1100; ep[1] = (k % 10) < 7;
            step(ep, (k % 10) == 0, 1'b0, "mode_hold");
        end
        bus.update = 1'b0;
        for (int j = 0; j < 20; j++) begin
            c = ((j % 10) < 5) ? (j % 10) : (9 - (j % 10));
            ep = 4'b0100; ep[1] = c < 3; ep[3] = c < 4;
            step(ep, (j % 10) == 0, j == 0, "center_n4");
        end

        // Center mode N=9, ch1 duty 3.
        bus.period_in = 16'd9;
        set_duty(16'd9, 16'd10, 16'd3, 16'd0);
        for (int j = 20; j < 30; j++) begin
            bus.update = (j == 22);
            c = ((j % 10) < 5) ? (j % 10) : (9 - (j % 10));
            ep = 4'b0100; ep[1] = c < 3; ep[3] = c < 4;
            step(ep, (j % 10) == 0, 1'b0, "center_n4_tail");
        end
        bus.update = 1'b0;
        for (int m = 0; m < 40; m++) begin
            c = ((m % 20) < 10) ? (m % 20) : (19 - (m % 20));
            ep = 4'b0100; ep[1] = c < 3; ep[3] = c < 9;
            step(ep, (m % 20) == 0, m == 0, "center_n9");
        end

        // Back to edge mode with ch1 inverted and duty 0.
        bus.center_mode = 1'b0;
        bus.invert_in   = 4'b0010;
        set_duty(16'd5, 16'd0, 16'd0, 16'd9);
        for (int m = 40; m < 60; m++) begin
            bus.update = (m == 40);
            c = ((m % 20) < 10) ? (m % 20) : (19 - (m % 20));
            ep = 4'b0100; ep[1] = c < 3; ep[3] = c < 9;
            step(ep, (m % 20) == 0, 1'b0, "center_n9_tail");
        end
        bus.update = 1'b0;
        for (int p = 0; p < 17; p++) begin
            if (p == 15) bus.enable = 1'b0;
            ep = 4'b0010; ep[0] = (p % 10) < 9; ep[3] = (p % 10) < 5;
            step(ep, (p % 10) == 0, p == 0, "invert_run");
        end
        for (int p = 0; p < 3; p++) step(4'b0010, 1'b0, 1'b0, "disabled_inv");

        // Re-enable restarts from cnt=0 with no ack.
        bus.enable = 1'b1;
        step(4'b0010, 1'b0, 1'b0, "reenable_c0");
        step(4'b0010, 1'b0, 1'b0, "reenable_c1");
        for (int q = 0; q < 12; q++) begin
            ep = 4'b0010; ep[0] = (q % 10) < 9; ep[3] = (q % 10) < 5;
            step(ep, (q % 10) == 0, 1'b0, "restart");
        end

        // Async reset mid-period while outputs are high.
        reset_n = 1'b0;
        step(4'b0000, 1'b0, 1'b0, "async_reset");
        reset_n = 1'b1;
        step(4'b0000, 1'b0, 1'b0, "reset_release");
        step(4'b0000, 1'b0, 1'b0, "reset_start");
        // All-zero actives: edge mode N=0 ticks every cycle, outputs stay 0.
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, 1'b0, "n0_tick");
        bus.update = 1'b1;
        step(4'b0000, 1'b1, 1'b0, "first_update");
        bus.update = 1'b0;
        step(4'b0000, 1'b1, 1'b0, "first_update_lat");
        for (int p = 0; p < 12; p++) begin
            ep = 4'b0010; ep[0] = (p % 10) < 9; ep[3] = (p % 10) < 5;
            step(ep, (p % 10) == 0, p == 0, "after_update");
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_gen_multi.md
# pwm_gen_multi

Multi-channel, parametrised PWM generator for the motor control module. NUM_CH channels share one period counter. Each channel has its own duty value and output polarity. Supports edge-aligned and center-aligned modes. Period, duty, mode and polarity settings are double-buffered: new values load only at a period boundary, so no runt or glitch pulses reach the H-bridge. The block sits between the AXI register file and the motor driver pins, in place of the single-channel generator.

## Interface
- NUM_CH, 4, number of PWM channels (1..16)
- CNT_WIDTH, 16, width of the counter, period and each duty field
- clk  in  1  system clock (100 MHz nominal)
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = run; 0 = hold the counter at 0 and drive outputs to their inactive level
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned (up/down)
- period_in  in  CNT_WIDTH  N = terminal count of the period counter
- duty_in  in  NUM_CH*CNT_WIDTH  duty of channel i in bits [i*CNT_WIDTH +: CNT_WIDTH]
- invert_in  in  NUM_CH  per-channel output polarity; 1 = active-low
- update  in  1  request to load the shadow registers; sticky until serviced
- pwm_out  out  NUM_CH  registered PWM outputs
- period_tick  out  1  one-cycle pulse in the first output cycle of each period
- update_ack  out  1  one-cycle pulse, coincident with period_tick, when the shadows were loaded

## Operation
- Active registers: N_act, duty_act[i], mode_act, inv_act. They are loaded from the inputs only:
  - at a boundary while an update is pending, or
  - on every cycle while enable=0 (transparent load).
- The pending flag is set by update=1 on any cycle. It is cleared when the load happens. An update arriving on the boundary cycle itself is serviced at that boundary.
- Input changes without update are ignored while enable=1.
- Edge mode:
  - cnt runs 0,1..N_act, then wraps to 0.
  - The period is N_act+1 cycles.
  - raw[i] = (cnt < duty_act[i]).
  - duty 0 gives 0%; duty ≥ N_act+1 gives 100%.
- Center mode:
  - cnt counts up 0..N_act, then down N_act..0. Each value is held for one cycle per direction, so both end values appear twice in a row.
  - The period is 2(N_act+1) cycles.
  - raw[i] = (cnt < duty_act[i]). High time is 2*min(duty, N_act+1) cycles, centred on the cnt=0 turnaround.
- Boundary = the last cycle of a period:
  - edge mode: cnt==N_act;
  - center mode: cnt==0 in the down direction.
- On the clock edge ending a boundary cycle:
  - cnt becomes 0 and the direction becomes up;
  - the shadows load if pending;
  - the new mode, period and duty govern the period that starts on that edge.
- The counter never exceeds N_act, because N_act changes only at a boundary.
- pwm_out[i] = raw[i] XOR inv_act[i], registered.
- enable=0:
  - cnt=0, direction up;
  - pwm_out = inv_act (inactive level);
  - period_tick=0, update_ack=0, pending cleared.
- All arithmetic is unsigned at CNT_WIDTH. Compares are full-width, with no truncation.

## Timing
- Reset (async assert, sync release) sets: cnt=0, direction up, all active registers 0, pending 0, pwm_out=0, period_tick=0, update_ack=0. This takes effect immediately, including mid-period.
- Output latency: pwm_out in cycle t+1 reflects cnt and the active registers of cycle t.
- period_tick is asserted in the cycle in which pwm_out reflects cnt=0 of a new period. It repeats every N_act+1 cycles (edge mode) or 2(N_act+1) cycles (center mode).
- Enable rise at edge E: cnt=0 is in effect for the cycle after E, counting starts, and the first period_tick occurs one cycle later.
  - The shadows loaded transparently while disabled are in effect immediately.
  - update_ack is not pulsed for this start.
- Enable fall: at the next edge cnt is forced to 0. pwm_out goes to inv_act one cycle later.
- Update latency: from update=1 to new values on pwm_out is at most one full period plus 1 cycle. update_ack and period_tick fire in the same cycle.
- N=0:
  - edge mode: the period is 1 cycle and period_tick stays high continuously;
  - center mode: the period is 2 cycles.

## Test plan
- Edge mode, NUM_CH=4, N=9, duties {0,3,10,15}, invert=0 -> ch0 constant 0; ch1 3 high / 7 low; ch2 and ch3 constant 1; period_tick every 10 cycles.
- Center mode, N=9, duty=3 -> 20-cycle period: 3 high, 14 low, 3 high, giving 6 contiguous high cycles across each wrap. period_tick coincides with the first of the trailing 3 high cycles of the pattern start.
- Edge mode, N=9, duty 3, running. Change duty_in to 7 with no update -> output unchanged. Pulse update at cycle 4 of a period -> 7-cycle pulses start at the next period_tick, with update_ack on that same cycle only.
- Update period 9->4 and mode edge->center on one pulse -> the switch occurs exactly at the boundary, cnt never exceeds 4 afterwards, and the next period is 10 cycles.
- invert=4'b0010, duty 0: ch1 is constant 1 while enabled. Drop enable mid-period -> pwm_out=4'b0010 two cycles later. Re-enable -> counting restarts from 0.
- Assert reset_n=0 mid-period with outputs high -> pwm_out=0 and period_tick=0 immediately (asynchronous). After release with enable=1, all active registers are 0, so outputs stay 0 until the first update.
